uart_rx_ctrl: RTL and testbench

- Controller that sequences the 8N1 UART receiver.
- Generates its 16x oversampling tick from a programmable divisor and gates reception until the line has been idle.
- Captures each completed byte from the receiver's done/data outputs into a small FIFO, and presents the bytes to the consumer over a valid/ready handshake.
- Also tracks overrun and reports an inter-character idle timeout.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_sync_fifo.sv | 57 +++++
 rtl/uart_rx_ctrl.sv | 148 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART receive controller.
package uart_pkg;

   localparam int OVERSAMPLE     = 16;
   localparam int FRAME_BITS     = 10;
   localparam int TICKS_PER_CHAR = OVERSAMPLE * FRAME_BITS;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_SYNC = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush; DEPTH must be a power of 2.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_data,
   input  logic                   i_pop,
   input  logic                   i_flush,
   output logic [WIDTH-1:0]       o_data,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_count = r_count;

   // A pop frees the head slot in the same cycle, so push at full is legal then.
   assign w_pop  = i_pop & ~o_empty & ~i_flush;
   assign w_push = i_push & (~o_full | w_pop) & ~i_flush;

   always_ff @(posedge clk) begin
      if (reset || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART 8N1 receive controller: baud tick, idle-line arming, byte FIFO, overrun.
// Optional idle timeout built when UART_RX_CTRL_TIMEOUT_EN is defined.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int DIV_W         = 16,
   parameter int FIFO_DEPTH    = 8,
   parameter int SYNC_TICKS    = 16,
   parameter int TIMEOUT_CHARS = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          i_enable,
   input  logic [DIV_W-1:0]              i_div,
   input  logic                          i_rxd,
   output logic                          o_clk_rx,
   input  logic                          i_rx_done,
   input  logic [7:0]                    i_rx_data,
   input  logic                          i_flush,
   output logic [7:0]                    o_data,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic [$clog2(FIFO_DEPTH):0]   o_count,
   output logic                          o_armed,
   output logic                          o_overrun,
   input  logic                          i_clr_overrun,
   output logic                          o_timeout
);

   localparam int SW = $clog2(SYNC_TICKS + 1);

   state_t           r_state;
   state_t           w_state_next;
   logic [DIV_W-1:0] r_baud_cnt;
   logic [DIV_W-1:0] w_div_m1;
   logic             w_tick;
   logic [SW-1:0]    r_sync_cnt;
   logic             r_done_d1;
   logic             r_done_d2;
   logic             w_push;
   logic             w_pop_eff;
   logic             w_full;
   logic             w_empty;
   logic             w_drop;
   logic             r_overrun;

   // Comparing with >= lets a smaller divisor take effect at once without a stray tick.
   assign w_div_m1 = (i_div == '0) ? '0 : i_div - 1'b1;
   assign w_tick   = (r_state != ST_OFF) && (r_baud_cnt >= w_div_m1);
   assign o_clk_rx = w_tick;

   always_ff @(posedge clk) begin
      if (reset || r_state == ST_OFF) r_baud_cnt <= '0;
      else if (w_tick)                r_baud_cnt <= '0;
      else                            r_baud_cnt <= r_baud_cnt + 1'b1;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_OFF:  if (i_enable) w_state_next = ST_SYNC;
         ST_SYNC: if (w_tick && i_rxd && r_sync_cnt == SW'(SYNC_TICKS - 1))
                     w_state_next = ST_RUN;
         ST_RUN:  w_state_next = ST_RUN;
         default: w_state_next = ST_OFF;
      endcase
      if (!i_enable) w_state_next = ST_OFF;
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_OFF;
      else       r_state <= w_state_next;
   end

   always_ff @(posedge clk) begin
      if (reset || r_state != ST_SYNC) r_sync_cnt <= '0;
      else if (w_tick)                 r_sync_cnt <= i_rxd ? r_sync_cnt + 1'b1 : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_done_d1 <= 1'b0;
         r_done_d2 <= 1'b0;
      end else begin
         r_done_d1 <= i_rx_done;
         r_done_d2 <= r_done_d1;
      end
   end

   assign w_push    = r_done_d1 & ~r_done_d2 & (r_state == ST_RUN);
   assign w_pop_eff = i_ready & ~w_empty;
   assign w_drop    = w_push & w_full & ~w_pop_eff & ~i_flush;

   uart_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_data  (i_rx_data),
      .i_pop   (i_ready),
      .i_flush (i_flush),
      .o_data  (o_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (o_count)
   );

   assign o_valid = ~w_empty;
   assign o_armed = (r_state == ST_RUN);

   always_ff @(posedge clk) begin
      if (reset)              r_overrun <= 1'b0;
      else if (w_drop)        r_overrun <= 1'b1;
      else if (i_clr_overrun) r_overrun <= 1'b0;
   end
   assign o_overrun = r_overrun;

`ifdef UART_RX_CTRL_TIMEOUT_EN
   localparam int TO_LIMIT = TIMEOUT_CHARS * TICKS_PER_CHAR;
   localparam int TW       = $clog2(TO_LIMIT + 1);

   logic [TW-1:0] r_idle_cnt;
   logic          r_timeout;

   // Counter parks at the limit so the pulse fires once per idle stretch.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_idle_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         if (w_push || w_pop_eff || i_flush || r_state != ST_RUN) begin
            r_idle_cnt <= '0;
         end else if (w_tick && !w_empty && r_idle_cnt != TW'(TO_LIMIT)) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
            r_timeout  <= (r_idle_cnt == TW'(TO_LIMIT - 1));
         end
      end
   end
   assign o_timeout = r_timeout;
`else
   // Always low; the term only keeps TIMEOUT_CHARS referenced in this build.
   assign o_timeout = 1'b0 & (TIMEOUT_CHARS == 0);
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed sequences, vector table, random FIFO traffic.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       reset, i_enable, i_rxd, i_rx_done, i_flush, i_ready, i_clr_overrun;
   logic [15:0] i_div;
   logic [7:0] i_rx_data;
   logic       o_clk_rx, o_valid, o_armed, o_overrun, o_timeout;
   logic [7:0] o_data;
   logic [3:0] o_count;

   int tests = 0;
   int fails = 0;
   int to_pulses = 0;

   logic [7:0] q[$];
   logic       m_ovr;

   typedef struct {
      int         op;          // 0 push, 1 pop, 2 flush, 3 clear overrun
      logic [7:0] d;
      logic       rdy;
      logic       fl;
      logic       clr;
      int         exp_cnt;
      logic [7:0] exp_head;
      logic       exp_ovr;
   } vec_t;
   vec_t tbl[26];

   uart_rx_ctrl dut (
      .clk(clk), .reset(reset), .i_enable(i_enable), .i_div(i_div), .i_rxd(i_rxd),
      .o_clk_rx(o_clk_rx), .i_rx_done(i_rx_done), .i_rx_data(i_rx_data), .i_flush(i_flush),
      .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_count(o_count),
      .o_armed(o_armed), .o_overrun(o_overrun), .i_clr_overrun(i_clr_overrun),
      .o_timeout(o_timeout)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (o_timeout === 1'b1) to_pulses++;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end else begin
         $display("ok   %s = %0h", name, act);
      end
   endtask

   task automatic tick_clk();
      @(posedge clk); #1;
   endtask

   task automatic check_model(input string tag);
      check({tag, "_count"}, o_count, q.size());
      check({tag, "_valid"}, o_valid, q.size() != 0);
      check({tag, "_ovr"}, o_overrun, m_ovr);
      if (q.size() != 0) check({tag, "_head"}, o_data, q[0]);
   endtask

   // Done rises, the push happens in the following cycle; ready/flush/clear ride on that cycle.
   task automatic push_op(input logic [7:0] d, input logic rdy, input logic fl, input logic clr);
      bit set;
      i_rx_done = 1'b1; i_rx_data = d;
      tick_clk();
      i_ready = rdy; i_flush = fl; i_clr_overrun = clr;
      tick_clk();
      i_ready = 1'b0; i_flush = 1'b0; i_clr_overrun = 1'b0; i_rx_done = 1'b0;
      tick_clk();
      set = 1'b0;
      if (fl) q.delete();
      else begin
         if (rdy && q.size() > 0) void'(q.pop_front());
         if (q.size() < DEPTH) q.push_back(d);
         else set = 1'b1;
      end
      if (set) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
   endtask

   task automatic pop_op();
      i_ready = 1'b1; tick_clk(); i_ready = 1'b0;
      if (q.size() > 0) void'(q.pop_front());
   endtask

   task automatic flush_op();
      i_flush = 1'b1; tick_clk(); i_flush = 1'b0;
      q.delete();
   endtask

   task automatic clr_op();
      i_clr_overrun = 1'b1; tick_clk(); i_clr_overrun = 1'b0;
      m_ovr = 1'b0;
   endtask

   task automatic wait_armed(input string tag);
      for (int c = 0; c < 200 && !o_armed; c++) tick_clk();
      check(tag, o_armed, 1);
   endtask

   // Counts ticks with i_div=3; optionally holds the line low across the 10th tick.
   task automatic run_sync(input bit drop, input int target, input string tag);
      int n = 0, prev = -1, first = -1, bad = 0, rise = -1, cyc = 0;
      i_enable = 1'b1;
      while (rise < 0 && cyc < 400) begin
         tick_clk(); cyc++;
         i_rxd = (drop && n == 9) ? 1'b0 : 1'b1;
         if (o_armed) rise = n;
         else if (o_clk_rx) begin
            if (first < 0) first = cyc;
            if (prev >= 0 && cyc - prev != 3) bad++;
            prev = cyc; n++;
         end
      end
      check({tag, "_first_tick"}, first, 3);
      check({tag, "_tick_period_errs"}, bad, 0);
      check({tag, "_armed_at_tick"}, rise, target);
   endtask

   initial begin
      int pulses, at;
      reset = 1'b1; i_enable = 1'b0; i_div = 16'd3; i_rxd = 1'b1; i_rx_done = 1'b0;
      i_rx_data = 8'h00; i_flush = 1'b0; i_ready = 1'b0; i_clr_overrun = 1'b0;
      m_ovr = 1'b0;
      repeat (3) tick_clk();
      check("rst_clk_rx", o_clk_rx, 0);
      check("rst_data", o_data, 0);
      check("rst_valid", o_valid, 0);
      check("rst_count", o_count, 0);
      check("rst_armed", o_armed, 0);
      check("rst_overrun", o_overrun, 0);
      check("rst_timeout", o_timeout, 0);
      reset = 1'b0;

      run_sync(1'b0, 16, "sync");
      i_enable = 1'b0; tick_clk();
      check("off_armed", o_armed, 0);
      check("off_clk_rx", o_clk_rx, 0);
      run_sync(1'b1, 26, "sync_drop");

      // Done edge while still synchronising must not reach the FIFO.
      i_enable = 1'b0; tick_clk();
      i_div = 16'd1; i_rxd = 1'b0; i_enable = 1'b1;
      repeat (2) tick_clk();
      i_rx_done = 1'b1; i_rx_data = 8'h77;
      repeat (4) tick_clk();
      i_rx_done = 1'b0;
      repeat (3) tick_clk();
      check("sync_no_push_count", o_count, 0);
      check("sync_still_unarmed", o_armed, 0);
      i_rxd = 1'b1;
      wait_armed("armed_div1");

      // Long done pulse with data arriving one cycle after the rise gives one push.
      i_rx_done = 1'b1; i_rx_data = 8'h00;
      tick_clk();
      i_rx_data = 8'hA5;
      repeat (47) tick_clk();
      i_rx_done = 1'b0;
      repeat (3) tick_clk();
      check("long_done_count", o_count, 1);
      check("long_done_valid", o_valid, 1);
      check("long_done_data", o_data, 8'hA5);
      q.push_back(8'hA5);
      flush_op();

      for (int i = 0; i < 9; i++)
         tbl[i] = '{0, 8'(i + 1), 1'b0, 1'b0, 1'b0, (i < 8) ? i + 1 : 8, 8'h01, i == 8};
      tbl[9]  = '{3, 8'h00, 1'b0, 1'b0, 1'b0, 8, 8'h01, 1'b0};
      tbl[10] = '{0, 8'h10, 1'b1, 1'b0, 1'b0, 8, 8'h02, 1'b0};
      tbl[11] = '{0, 8'h11, 1'b0, 1'b1, 1'b0, 0, 8'h00, 1'b0};
      tbl[12] = '{0, 8'hA5, 1'b0, 1'b0, 1'b0, 1, 8'hA5, 1'b0};
      tbl[13] = '{1, 8'h00, 1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b0};
      tbl[14] = '{1, 8'h00, 1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b0};
      tbl[15] = '{0, 8'h3C, 1'b1, 1'b0, 1'b0, 1, 8'h3C, 1'b0};
      for (int i = 0; i < 7; i++)
         tbl[16 + i] = '{0, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0, i + 2, 8'h3C, 1'b0};
      tbl[23] = '{0, 8'h50, 1'b0, 1'b0, 1'b1, 8, 8'h3C, 1'b1};
      tbl[24] = '{2, 8'h00, 1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b1};
      tbl[25] = '{3, 8'h00, 1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b0};

      for (int i = 0; i < 26; i++) begin
         case (tbl[i].op)
            0: push_op(tbl[i].d, tbl[i].rdy, tbl[i].fl, tbl[i].clr);
            1: pop_op();
            2: flush_op();
            default: clr_op();
         endcase
         check($sformatf("vec%0d_count", i), o_count, tbl[i].exp_cnt);
         check($sformatf("vec%0d_ovr", i), o_overrun, tbl[i].exp_ovr);
         if (tbl[i].exp_cnt != 0) check($sformatf("vec%0d_head", i), o_data, tbl[i].exp_head);
      end

      for (int i = 0; i < 300; i++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r <= 5)
            push_op(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 7) == 0);
         else if (r <= 7) pop_op();
         else if (r == 8) begin
            if ($urandom_range(0, 3) == 0) flush_op(); else pop_op();
         end else clr_op();
         check_model($sformatf("rnd%0d", i));
      end

      // Disabling stops ticks at once and keeps queued bytes.
      push_op(8'h99, 1'b0, 1'b0, 1'b0);
      check("run_tick", o_clk_rx, 1);
      i_enable = 1'b0; tick_clk();
      check("dis_clk_rx", o_clk_rx, 0);
      check("dis_armed", o_armed, 0);
      check_model("dis");

      i_enable = 1'b1;
      wait_armed("rearm");
      flush_op();
      i_rx_done = 1'b1; i_rx_data = 8'h5A;
      tick_clk(); tick_clk();
      i_rx_done = 1'b0;
      q.push_back(8'h5A);
      check("to_held_count", o_count, 1);
      pulses = 0; at = -1;
      for (int k = 1; k <= 1000; k++) begin
         tick_clk();
         if (o_timeout) begin pulses++; at = k; end
      end
`ifdef UART_RX_CTRL_TIMEOUT_EN
      check("to_pulses", pulses, 1);
      check("to_delay_ok", (at >= 639 && at <= 641), 1);
      push_op(8'h61, 1'b0, 1'b0, 1'b0);
      push_op(8'h62, 1'b0, 1'b0, 1'b0);
      pulses = 0;
      for (int k = 0; k < 300; k++) begin tick_clk(); if (o_timeout) pulses++; end
      pop_op();
      for (int k = 0; k < 600; k++) begin tick_clk(); if (o_timeout) pulses++; end
      check("to_restart_no_pulse", pulses, 0);
      for (int k = 0; k < 100; k++) begin tick_clk(); if (o_timeout) pulses++; end
      check("to_after_pop_pulse", pulses, 1);
`else
      check("to_disabled_pulses", pulses, 0);
`endif

      // Reset in the middle of a frame with bytes queued and overrun set.
      flush_op();
      for (int i = 0; i < 9; i++) push_op(8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
      check("pre_rst_ovr", o_overrun, 1);
      i_rx_done = 1'b1;
      tick_clk();
      reset = 1'b1;
      tick_clk();
      check("mid_rst_clk_rx", o_clk_rx, 0);
      check("mid_rst_data", o_data, 0);
      check("mid_rst_valid", o_valid, 0);
      check("mid_rst_count", o_count, 0);
      check("mid_rst_armed", o_armed, 0);
      check("mid_rst_overrun", o_overrun, 0);
      check("mid_rst_timeout", o_timeout, 0);
      reset = 1'b0; i_rx_done = 1'b0;
      q.delete(); m_ovr = 1'b0;
      repeat (2) tick_clk();
`ifndef UART_RX_CTRL_TIMEOUT_EN
      check("to_never_asserted", to_pulses, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
